// File: rtl/frame_uart_tx.sv
// Frame buffer read-back transmitter: sends header 0xA5 and then every pixel over UART 8N1.
// Optional macro FRAME_TX_CHECKSUM_EN appends the mod-256 sum of the pixel bytes.
module frame_uart_tx #(
   parameter int CLK_FREQ    = 50000000,
   parameter int BAUD_RATE   = 115200,
   parameter int PIXELS      = 256,
   parameter int ADDR_WIDTH  = 8,
   parameter int COLOR_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   dump_req,
   output logic [ADDR_WIDTH-1:0]  rd_addr,
   input  logic [COLOR_DEPTH-1:0] rd_data,
   output logic                   tx,
   output logic                   busy,
   output logic                   done
);
   localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BIT_W    = $clog2(COLOR_DEPTH + 2);

   localparam logic [CNT_W-1:0]       CNT_LAST      = CNT_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0]       BIT_LAST_DATA = BIT_W'(COLOR_DEPTH);
   localparam logic [BIT_W-1:0]       BIT_STOP      = BIT_W'(COLOR_DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0]  ADDR_LAST     = ADDR_WIDTH'(PIXELS - 1);
   localparam logic [COLOR_DEPTH-1:0] HEADER_BYTE   = COLOR_DEPTH'(8'hA5);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_PIXEL,
`ifdef FRAME_TX_CHECKSUM_EN
      S_CHECKSUM,
`endif
      S_FINISH
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       baud_cnt;
   logic [BIT_W-1:0]       bit_idx;
   logic [COLOR_DEPTH-1:0] shreg;
   logic                   last_pix;
`ifdef FRAME_TX_CHECKSUM_EN
   logic [COLOR_DEPTH-1:0] sum;
`endif

   // bit_idx: 0 = start, 1..COLOR_DEPTH = data (LSB first), COLOR_DEPTH+1 = stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_addr  <= '0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         last_pix <= 1'b0;
`ifdef FRAME_TX_CHECKSUM_EN
         sum      <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               tx      <= 1'b1;
               busy    <= 1'b0;
               rd_addr <= '0;
               if (dump_req) begin
                  state    <= S_HEADER;
                  busy     <= 1'b1;
                  tx       <= 1'b0;
                  shreg    <= HEADER_BYTE;
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  last_pix <= 1'b0;
`ifdef FRAME_TX_CHECKSUM_EN
                  sum      <= '0;
`endif
               end
            end
`ifdef FRAME_TX_CHECKSUM_EN
            S_HEADER, S_PIXEL, S_CHECKSUM: begin
`else
            S_HEADER, S_PIXEL: begin
`endif
               if (baud_cnt != CNT_LAST) begin
                  baud_cnt <= baud_cnt + 1'b1;
               end else begin
                  baud_cnt <= '0;
                  if (bit_idx == BIT_STOP) begin
                     // End of stop bit: the next start bit follows with no gap.
                     bit_idx <= '0;
                     tx      <= 1'b0;
                     if (state == S_HEADER || (state == S_PIXEL && !last_pix)) begin
                        state    <= S_PIXEL;
                        shreg    <= rd_data;
                        last_pix <= (rd_addr == ADDR_LAST);
`ifdef FRAME_TX_CHECKSUM_EN
                        sum      <= sum + rd_data;
`endif
                     end
`ifdef FRAME_TX_CHECKSUM_EN
                     else if (state == S_PIXEL) begin
                        state <= S_CHECKSUM;
                        shreg <= sum;
                     end
`endif
                     else begin
                        state   <= S_FINISH;
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rd_addr <= '0;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     if (bit_idx == BIT_LAST_DATA) begin
                        tx <= 1'b1;
                        // Present the next pixel address for the whole stop bit.
                        if (state == S_PIXEL && !last_pix) begin
                           rd_addr <= rd_addr + 1'b1;
                        end
                     end else begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                     end
                  end
               end
            end
            S_FINISH: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_uart_tx.sv
// Bench for frame_uart_tx: UART decoder plus a queue-based frame model built from the buffer contents.
module tb_frame_uart_tx;
   localparam int BD     = 10;
   localparam int PIX    = 256;
   localparam int BUDGET = 30000;

   logic       clk;
   logic       rst;
   logic       dump_req;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       tx;
   logic       busy;
   logic       done;

   logic [7:0] mem [PIX];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   int         start_q [$];
   int         addr_q [$];
   int         cyc;
   int         checks;
   int         errors;
   int         done_cnt;
   int         frame_errs;
   bit         mon_active;
   int         mon_cnt;
   bit         glitch_en;
   logic [7:0] mon_byte;
   logic [7:0] stop_addr;
   bit         addr_stable;

   frame_uart_tx #(
      .CLK_FREQ(1000000), .BAUD_RATE(100000), .PIXELS(PIX), .ADDR_WIDTH(8), .COLOR_DEPTH(8)
   ) dut (
      .clk(clk), .rst(rst), .dump_req(dump_req), .rd_addr(rd_addr),
      .rd_data(rd_data), .tx(tx), .busy(busy), .done(done)
   );

   // Buffer read port; in glitch mode the data is corrupted mid-byte, where it must not be latched.
   assign rd_data = (glitch_en && mon_active && mon_cnt >= 2*BD && mon_cnt <= 8*BD)
                    ? ~mem[rd_addr] : mem[rd_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // UART decoder: bit k of a byte spans cycles 10k..10k+9 after the start-bit cycle.
   initial begin
      mon_active = 1'b0;
      mon_cnt = 0;
      done_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_active = 1'b0;
         end else if (!mon_active) begin
            if (tx === 1'b0) begin
               mon_active = 1'b1;
               mon_cnt = 0;
               addr_stable = 1'b1;
               start_q.push_back(cyc);
            end
         end else begin
            mon_cnt++;
         end
         if (!rst && done === 1'b1) done_cnt++;
         if (mon_active && !rst) begin
            if (mon_cnt % BD == BD/2) begin
               if (mon_cnt / BD == 0) begin
                  if (tx !== 1'b0) frame_errs++;
               end else if (mon_cnt / BD <= 8) begin
                  mon_byte[mon_cnt/BD - 1] = tx;
               end else begin
                  if (tx !== 1'b1) frame_errs++;
                  got_q.push_back(mon_byte);
               end
            end
            if (mon_cnt == 9*BD) stop_addr = rd_addr;
            else if (mon_cnt > 9*BD && rd_addr !== stop_addr) addr_stable = 1'b0;
            if (mon_cnt == 10*BD - 1) begin
               addr_q.push_back(addr_stable ? int'(stop_addr) : -1);
               mon_active = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic build_expected();
      int s;
      s = 0;
      exp_q = {};
      exp_q.push_back(8'hA5);
      for (int i = 0; i < PIX; i++) begin
         exp_q.push_back(mem[i]);
         s += int'(mem[i]);
      end
`ifdef FRAME_TX_CHECKSUM_EN
      exp_q.push_back(8'(s % 256));
`endif
   endtask

   // Starts one dump (called right after a negedge) and checks the whole frame.
   task automatic run_dump(input string name, input int req_again_at, input bit check_addr);
      bit         seen;
      int         n;
      int         done_cyc;
      logic       busy_prev;
      logic       busy_at_done;
      logic [31:0] g;
      build_expected();
      got_q = {}; start_q = {}; addr_q = {};
      done_cnt = 0; frame_errs = 0;
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      chk({name, "_busy_rise"}, busy, 1);
      chk({name, "_start_bit"}, tx, 0);
      seen = 1'b0; n = 0; done_cyc = 0; busy_prev = 1'b0; busy_at_done = 1'bx;
      while (!seen && n < BUDGET) begin
         @(negedge clk);
         n++;
         dump_req = (n == req_again_at);
         if (done === 1'b1) begin
            seen = 1'b1;
            done_cyc = cyc;
            busy_at_done = busy;
         end else begin
            busy_prev = busy;
         end
      end
      dump_req = 1'b0;
      chk({name, "_done_seen"}, seen, 1);
      chk({name, "_busy_before_done"}, busy_prev, 1);
      chk({name, "_busy_at_done"}, busy_at_done, 0);
      g = 'x;
      if (start_q.size() > 0) g = done_cyc - start_q[0];
      chk({name, "_done_latency"}, g, 10*BD*exp_q.size());
      repeat (30) @(negedge clk);
      chk({name, "_byte_count"}, got_q.size(), exp_q.size());
      chk({name, "_done_count"}, done_cnt, 1);
      chk({name, "_framing"}, frame_errs, 0);
      chk({name, "_idle_tx"}, tx, 1);
      chk({name, "_idle_addr"}, rd_addr, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         g = 'x;
         if (i < got_q.size()) g = got_q[i];
         chk($sformatf("%s_byte%0d", name, i), g, exp_q[i]);
      end
      if (check_addr) begin
         for (int k = 0; k < PIX; k++) begin
            g = 'x;
            if (k < addr_q.size()) g = addr_q[k];
            chk($sformatf("%s_stop_addr%0d", name, k), g, k);
         end
      end
   endtask

   initial begin
      int target;
      int guard;
      checks = 0; errors = 0;
      rst = 1'b1; dump_req = 1'b0; glitch_en = 1'b0;
      for (int i = 0; i < PIX; i++) mem[i] = 8'(i);

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("reset_tx_c%0d", c), tx, 1);
         chk($sformatf("reset_busy_c%0d", c), busy, 0);
         chk($sformatf("reset_done_c%0d", c), done, 0);
         chk($sformatf("reset_addr_c%0d", c), rd_addr, 0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Incrementing frame with an ignored request mid-dump.
      run_dump("incr", 5000, 1'b0);

      // Constant frame straight after the previous done, rd_addr stop-bit tracking.
      for (int i = 0; i < PIX; i++) mem[i] = 8'hFF;
      run_dump("const", -1, 1'b1);

      // Reset during the data bits of the 10th pixel.
      for (int i = 0; i < PIX; i++) mem[i] = 8'($urandom_range(0, 255));
      got_q = {}; start_q = {}; done_cnt = 0;
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      @(negedge clk);
      target = cyc;
      if (start_q.size() > 0) target = start_q[0] + 10*10*BD + $urandom_range(BD, 9*BD - 1);
      guard = 0;
      while (cyc < target && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      chk("abort_bytes_before", got_q.size(), 10);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_tx", tx, 1);
      chk("abort_busy", busy, 0);
      chk("abort_addr", rd_addr, 0);
      chk("abort_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle_tx", tx, 1);

      // Fresh random frame after the abort, with mid-byte rd_data corruption.
      for (int i = 0; i < PIX; i++) mem[i] = 8'($urandom_range(0, 255));
      glitch_en = 1'b1;
      run_dump("restart", -1, 1'b0);
      glitch_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
